// File: rtl/frame_header_builder_pkg.sv
// Shared definitions for the frame header builder and the downstream output controller:
// header field layout, CRC-32 constants, FSM state encoding and the default queue count.
package frame_header_builder_pkg;

   localparam int PORT_NUB_TOTAL   = 16;

   localparam int PRI_NUM_BIT      = 3;
   localparam int CRC32_LENGTH     = 32;
   localparam int DATABUF_HIGH_NUM = 7;

   localparam int HDR_PRI_LSB   = 0;
   localparam int HDR_CRC_LSB   = HDR_PRI_LSB + PRI_NUM_BIT;
   localparam int HDR_CNT_LSB   = HDR_CRC_LSB + CRC32_LENGTH;
   localparam int HDR_USED_BITS = HDR_CNT_LSB + DATABUF_HIGH_NUM;

   // CRC-32, MSB-first, seeded with all ones, no reflection and no final inversion.
   localparam logic [CRC32_LENGTH-1:0] CRC32_POLY = 32'h04C1_1DB7;
   localparam logic [CRC32_LENGTH-1:0] CRC32_INIT = 32'hFFFF_FFFF;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_COLLECT = 2'd1;
   localparam logic [1:0] ST_HDR     = 2'd2;
   localparam logic [1:0] ST_PAYLOAD = 2'd3;

   // Field order matches the header word from the MSB of the used region down to bit 0.
   typedef struct packed {
      logic [DATABUF_HIGH_NUM-1:0] count;
      logic [CRC32_LENGTH-1:0]     crc;
      logic [PRI_NUM_BIT-1:0]      pri;
   } hdr_fields_t;

endpackage

// File: rtl/crc32_64bit.sv
// Running CRC-32 over one DATA_WIDTH word per enabled cycle. rst restarts the CRC from
// the seed; when asserted together with crc_en the current word is the first of the frame.
module crc32_64bit
   import frame_header_builder_pkg::*;
#(
   parameter int DATA_WIDTH = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    rst,
   input  logic                    crc_en,
   input  logic [DATA_WIDTH-1:0]   data_in,
   output logic [CRC32_LENGTH-1:0] crc_out
);

   function automatic logic [CRC32_LENGTH-1:0] crc_step(
      input logic [CRC32_LENGTH-1:0] c_in,
      input logic [DATA_WIDTH-1:0]   d
   );
      logic [CRC32_LENGTH-1:0] c;
      logic                    fb;
      c = c_in;
      for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
         fb = c[CRC32_LENGTH-1] ^ d[i];
         c  = {c[CRC32_LENGTH-2:0], 1'b0} ^ (fb ? CRC32_POLY : '0);
      end
      return c;
   endfunction

   logic [CRC32_LENGTH-1:0] seed;

   assign seed = rst ? CRC32_INIT : crc_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc_out <= '0;
      end else if (crc_en) begin
         crc_out <= crc_step(seed, data_in);
      end else if (rst) begin
         crc_out <= CRC32_INIT;
      end
   end

endmodule

// File: rtl/frame_header_builder.sv
// Buffers a frame, then writes a header word (pri, CRC-32, word count) followed by the payload
// into the selected port queue. FRAME_OVERSIZE_DROP_EN: drop oversize frames instead of truncating.
module frame_header_builder
   import frame_header_builder_pkg::*;
#(
   parameter int DATA_WIDTH     = 64,
   parameter int PORT_NUB_TOTAL = frame_header_builder_pkg::PORT_NUB_TOTAL,
   parameter int MAX_WORDS      = 127
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              wr_sop,
   input  logic                              wr_eop,
   input  logic                              wr_vld,
   input  logic [DATA_WIDTH-1:0]             wr_data,
   input  logic [$clog2(PORT_NUB_TOTAL)-1:0] wr_port,
   input  logic [PRI_NUM_BIT-1:0]            wr_pri,
   output logic                              wr_ready,
   input  logic [PORT_NUB_TOTAL-1:0]         q_full,
   output logic [PORT_NUB_TOTAL-1:0]         q_wr_en,
   output logic [DATA_WIDTH-1:0]             q_wr_data,
   output logic                              err_proto,
   output logic                              err_oversize,
   output logic [1:0]                        dbg_state
);

   localparam int PORT_WIDTH = $clog2(PORT_NUB_TOTAL);
   localparam logic [DATABUF_HIGH_NUM-1:0] MAX_CNT = DATABUF_HIGH_NUM'(MAX_WORDS);

   // Handshake: a beat transfers when wr_vld && wr_ready; wr_ready depends only on state,
   // never on wr_vld, so the source may hold a beat until it is taken.

   logic [1:0]                  state;
   logic [PORT_WIDTH-1:0]       port_q;
   logic [PRI_NUM_BIT-1:0]      pri_q;
   logic [DATABUF_HIGH_NUM-1:0] count;
   logic [DATABUF_HIGH_NUM-1:0] rd_idx;
   logic                        ovf_q;
   logic [DATA_WIDTH-1:0]       mem [0:MAX_WORDS-1];

   logic                        beat;
   logic                        drop;
   logic                        full_now;
   logic                        buf_we;
   logic                        crc_seed;
   logic [DATABUF_HIGH_NUM-1:0] buf_widx;
   logic [CRC32_LENGTH-1:0]     crc_val;
   hdr_fields_t                 hdr;

`ifdef FRAME_OVERSIZE_DROP_EN
   // After the overflow word the rest of the frame is swallowed up to its eop.
   assign drop = ovf_q && (state == ST_COLLECT);
   localparam logic [1:0] OVF_EOP_STATE = ST_IDLE;
`else
   assign drop = 1'b0;
   localparam logic [1:0] OVF_EOP_STATE = ST_HDR;
`endif

   assign wr_ready  = (state == ST_IDLE) || (state == ST_COLLECT);
   assign beat      = wr_vld && wr_ready;
   assign full_now  = q_full[port_q];
   assign dbg_state = state;
   assign buf_widx  = wr_sop ? '0 : count;
   assign hdr       = '{count: count, crc: crc_val, pri: pri_q};

   always_comb begin
      buf_we   = 1'b0;
      crc_seed = 1'b0;
      if (beat) begin
         if (wr_sop && !drop) begin
            buf_we   = 1'b1;
            crc_seed = 1'b1;
         end else if ((state == ST_COLLECT) && !drop && (count != MAX_CNT)) begin
            buf_we = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (buf_we) begin
         mem[buf_widx] <= wr_data;
      end
   end

   crc32_64bit #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_crc (
      .clk     (clk),
      .rst_n   (rst_n),
      .rst     (crc_seed),
      .crc_en  (buf_we),
      .data_in (wr_data),
      .crc_out (crc_val)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         port_q       <= '0;
         pri_q        <= '0;
         count        <= '0;
         rd_idx       <= '0;
         ovf_q        <= 1'b0;
         err_proto    <= 1'b0;
         err_oversize <= 1'b0;
      end else begin
         err_proto    <= 1'b0;
         err_oversize <= 1'b0;
         case (state)
            ST_IDLE, ST_COLLECT: begin
               if (beat) begin
                  if (wr_sop && !drop) begin
                     // A sop while collecting abandons the partial frame.
                     port_q    <= wr_port;
                     pri_q     <= wr_pri;
                     count     <= DATABUF_HIGH_NUM'(1);
                     ovf_q     <= 1'b0;
                     err_proto <= (state == ST_COLLECT);
                     state     <= wr_eop ? ST_HDR : ST_COLLECT;
                  end else if (state == ST_IDLE) begin
                     err_proto <= 1'b1;
                  end else if (drop) begin
                     if (wr_eop) begin
                        state <= ST_IDLE;
                     end
                  end else if (count == MAX_CNT) begin
                     if (!ovf_q) begin
                        err_oversize <= 1'b1;
                     end
                     ovf_q <= 1'b1;
                     if (wr_eop) begin
                        state <= OVF_EOP_STATE;
                     end
                  end else begin
                     count <= count + DATABUF_HIGH_NUM'(1);
                     if (wr_eop) begin
                        state <= ST_HDR;
                     end
                  end
               end
            end
            ST_HDR: begin
               if (!full_now) begin
                  state  <= ST_PAYLOAD;
                  rd_idx <= '0;
               end
            end
            ST_PAYLOAD: begin
               if (!full_now) begin
                  rd_idx <= rd_idx + DATABUF_HIGH_NUM'(1);
                  if (rd_idx == count - DATABUF_HIGH_NUM'(1)) begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      q_wr_en   = '0;
      q_wr_data = '0;
      if (((state == ST_HDR) || (state == ST_PAYLOAD)) && !full_now) begin
         q_wr_en[port_q] = 1'b1;
         q_wr_data       = (state == ST_HDR) ? DATA_WIDTH'(hdr) : mem[rd_idx];
      end
   end

endmodule

// File: tb/tb_frame_header_builder.sv
// Directed self-checking bench for frame_header_builder; the oversize expectations follow
// FRAME_OVERSIZE_DROP_EN when the build defines it.
module tb_frame_header_builder;
   import frame_header_builder_pkg::*;

   localparam int DW = 64;
   localparam int NP = 16;
   localparam int MW = 127;

   logic          clk;
   logic          rst_n;
   logic          wr_sop;
   logic          wr_eop;
   logic          wr_vld;
   logic [DW-1:0] wr_data;
   logic [3:0]    wr_port;
   logic [2:0]    wr_pri;
   logic          wr_ready;
   logic [NP-1:0] q_full;
   logic [NP-1:0] q_wr_en;
   logic [DW-1:0] q_wr_data;
   logic          err_proto;
   logic          err_oversize;
   logic [1:0]    dbg_state;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int n_errp   = 0;
   int n_erro   = 0;

   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] cap_data[$];
   logic [NP-1:0] cap_en[$];
   int            cap_cyc[$];

   frame_header_builder #(
      .DATA_WIDTH     (DW),
      .PORT_NUB_TOTAL (NP),
      .MAX_WORDS      (MW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_sop       (wr_sop),
      .wr_eop       (wr_eop),
      .wr_vld       (wr_vld),
      .wr_data      (wr_data),
      .wr_port      (wr_port),
      .wr_pri       (wr_pri),
      .wr_ready     (wr_ready),
      .q_full       (q_full),
      .q_wr_en      (q_wr_en),
      .q_wr_data    (q_wr_data),
      .err_proto    (err_proto),
      .err_oversize (err_oversize),
      .dbg_state    (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Queue-side monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (q_wr_en != '0) begin
         cap_data.push_back(q_wr_data);
         cap_en.push_back(q_wr_en);
         cap_cyc.push_back(cyc);
      end
      if (err_proto)    n_errp++;
      if (err_oversize) n_erro++;
   end

   // ---------------- reference model ----------------
   // Word-at-a-time formulation: fold 32 data bits into the register, then 32 plain shifts.
   function automatic logic [31:0] model_crc(input logic [31:0] c_in, input logic [63:0] d);
      logic [31:0] c;
      c = c_in;
      for (int h = 1; h >= 0; h--) begin
         c = c ^ d[h*32 +: 32];
         for (int b = 0; b < 32; b++) begin
            c = c[31] ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
         end
      end
      return c;
   endfunction

   function automatic logic [63:0] word_of(input int f, input int i);
      return {8'hA0 + 8'(f), 24'(i), 32'h5EED_0000 ^ (32'(i) * 32'h0001_0003)};
   endfunction

   function automatic int data_diff();
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i >= cap_data.size() || cap_data[i] !== exp_q[i]) return i;
      end
      return -1;
   endfunction

   // ---------------- drivers ----------------
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      exp_q.delete();
      cap_data.delete();
      cap_en.delete();
      cap_cyc.delete();
      n_errp = 0;
      n_erro = 0;
   endtask

   task automatic drive_beat(input logic sop, input logic eop, input logic [63:0] d,
                             input logic [3:0] port, input logic [2:0] pri);
      wr_vld  = 1'b1;
      wr_sop  = sop;
      wr_eop  = eop;
      wr_data = d;
      wr_port = port;
      wr_pri  = pri;
      @(posedge clk);
      #1;
      wr_vld = 1'b0;
      wr_sop = 1'b0;
      wr_eop = 1'b0;
   endtask

   // Sends n beats back to back and queues the expected header plus kept payload.
   // t_hdr is the cycle right after the eop beat is accepted.
   task automatic send_frame(input logic [3:0] port, input logic [2:0] pri, input int f,
                             input int n, output int t_hdr);
      logic [31:0] c;
      int          kept;
      kept = (n > MW) ? MW : n;
      c    = 32'hFFFF_FFFF;
      for (int i = 0; i < kept; i++) c = model_crc(c, word_of(f, i));
      exp_q.push_back({22'd0, 7'(kept), c, pri});
      for (int i = 0; i < kept; i++) exp_q.push_back(word_of(f, i));
      for (int i = 0; i < n; i++) drive_beat(i == 0, i == n - 1, word_of(f, i), port, pri);
      t_hdr = cyc;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n   = 1'b0;
      wr_vld  = 1'b1;
      wr_sop  = 1'b0;
      wr_eop  = 1'b0;
      wr_data = '0;
      wr_port = '0;
      wr_pri  = '0;
      q_full  = '0;
      idle(3);
      n_checks++;
      if (wr_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", wr_ready); else n_pass++;
      n_checks++;
      if (q_wr_en !== '0) $display("FAIL reset_wr_en: got %h expected 0", q_wr_en); else n_pass++;
      n_checks++;
      if (q_wr_data !== '0) $display("FAIL reset_wr_data: got %h expected 0", q_wr_data); else n_pass++;
      n_checks++;
      if (err_proto !== 1'b0 || err_oversize !== 1'b0)
         $display("FAIL reset_err: got %b%b expected 00", err_proto, err_oversize);
      else n_pass++;
      n_checks++;
      if (dbg_state !== ST_IDLE) $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); else n_pass++;
      wr_vld = 1'b0;
      rst_n  = 1'b1;
      idle(2);
   endtask

   task automatic test_basic();
      int t;
      int d;
      int bad_en;
      int bad_cyc;
      clear_mon();
      send_frame(4'd5, 3'd2, 1, 3, t);
      idle(8);
      n_checks++;
      if (cap_data.size() !== 4) $display("FAIL basic_count: got %0d writes expected 4", cap_data.size()); else n_pass++;
      n_checks++;
      if (cap_cyc.size() < 1 || cap_cyc[0] !== t)
         $display("FAIL basic_hdr_latency: got cycle %0d expected %0d", (cap_cyc.size() > 0) ? cap_cyc[0] : -1, t);
      else n_pass++;
      d = data_diff();
      n_checks++;
      if (d !== -1) $display("FAIL basic_data: word %0d got %h expected %h", d, cap_data[d], exp_q[d]); else n_pass++;
      bad_en  = 0;
      bad_cyc = 0;
      for (int i = 0; i < cap_en.size(); i++) begin
         if (cap_en[i] !== 16'h0020) bad_en++;
         if (cap_cyc[i] !== t + i) bad_cyc++;
      end
      n_checks++;
      if (bad_en !== 0) $display("FAIL basic_onehot: got %0d bad strobes expected 0", bad_en); else n_pass++;
      n_checks++;
      if (bad_cyc !== 0) $display("FAIL basic_no_bubble: got %0d gaps expected 0", bad_cyc); else n_pass++;
      n_checks++;
      if (dbg_state !== ST_IDLE) $display("FAIL basic_end_state: got %0d expected %0d", dbg_state, ST_IDLE); else n_pass++;
   endtask

   task automatic test_single();
      int t;
      int d;
      clear_mon();
      send_frame(4'd0, 3'd7, 2, 1, t);
      repeat (3) @(negedge clk);
      n_checks++;
      if (dbg_state !== ST_IDLE) $display("FAIL single_idle_after_2: got %0d expected %0d", dbg_state, ST_IDLE); else n_pass++;
      idle(4);
      n_checks++;
      if (cap_data.size() !== 2) $display("FAIL single_count: got %0d writes expected 2", cap_data.size()); else n_pass++;
      d = data_diff();
      n_checks++;
      if (d !== -1) $display("FAIL single_data: word %0d got %h expected %h", d, cap_data[d], exp_q[d]); else n_pass++;
      n_checks++;
      if (cap_en.size() < 2 || cap_en[0] !== 16'h0001 || cap_en[1] !== 16'h0001 || cap_cyc[1] !== t + 1)
         $display("FAIL single_strobe: got %h at %0d expected 0001 at %0d",
                  (cap_en.size() > 1) ? cap_en[1] : 16'hxxxx, (cap_cyc.size() > 1) ? cap_cyc[1] : -1, t + 1);
      else n_pass++;
   endtask

   task automatic test_stall();
      int t;
      int d;
      int rdy_hi;
      int wr_seen;
      int bad_cyc;
      int exp_off[5] = '{0, 1, 6, 7, 8};
      clear_mon();
      q_full = 16'h8010;
      send_frame(4'd5, 3'd6, 3, 4, t);
      idle(2);
      q_full  = 16'h8030;
      rdy_hi  = 0;
      wr_seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (wr_ready !== 1'b0) rdy_hi++;
         if (q_wr_en !== '0) wr_seen++;
         @(posedge clk);
         #1;
      end
      q_full = 16'h8010;
      idle(6);
      q_full = '0;
      n_checks++;
      if (rdy_hi !== 0) $display("FAIL stall_ready: got %0d ready cycles expected 0", rdy_hi); else n_pass++;
      n_checks++;
      if (wr_seen !== 0) $display("FAIL stall_no_write: got %0d writes expected 0", wr_seen); else n_pass++;
      n_checks++;
      if (cap_data.size() !== 5) $display("FAIL stall_count: got %0d writes expected 5", cap_data.size()); else n_pass++;
      d = data_diff();
      n_checks++;
      if (d !== -1) $display("FAIL stall_data: word %0d got %h expected %h", d, cap_data[d], exp_q[d]); else n_pass++;
      bad_cyc = 0;
      for (int i = 0; i < 5; i++) begin
         if (i >= cap_cyc.size() || cap_cyc[i] !== t + exp_off[i] || cap_en[i] !== 16'h0020) bad_cyc++;
      end
      n_checks++;
      if (bad_cyc !== 0) $display("FAIL stall_timing: got %0d misplaced writes expected 0", bad_cyc); else n_pass++;
   endtask

   task automatic test_proto();
      int t;
      int d;
      int bad_en;
      clear_mon();
      drive_beat(1'b0, 1'b0, 64'hDEAD_BEEF_0000_0001, 4'd1, 3'd0);
      idle(2);
      n_checks++;
      if (n_errp !== 1 || cap_data.size() !== 0)
         $display("FAIL proto_idle_stray: got %0d pulses %0d writes expected 1 pulse 0 writes", n_errp, cap_data.size());
      else n_pass++;
      drive_beat(1'b1, 1'b0, word_of(4, 0), 4'd3, 3'd1);
      drive_beat(1'b0, 1'b0, word_of(4, 1), 4'd3, 3'd1);
      send_frame(4'd9, 3'd4, 5, 2, t);
      idle(6);
      n_checks++;
      if (n_errp !== 2) $display("FAIL proto_sop_in_collect: got %0d pulses expected 2", n_errp); else n_pass++;
      n_checks++;
      if (cap_data.size() !== 3) $display("FAIL proto_count: got %0d writes expected 3", cap_data.size()); else n_pass++;
      d = data_diff();
      n_checks++;
      if (d !== -1) $display("FAIL proto_data: word %0d got %h expected %h", d, cap_data[d], exp_q[d]); else n_pass++;
      bad_en = 0;
      for (int i = 0; i < cap_en.size(); i++) if (cap_en[i] !== 16'h0200) bad_en++;
      n_checks++;
      if (bad_en !== 0) $display("FAIL proto_port: got %0d bad strobes expected 0", bad_en); else n_pass++;
   endtask

   task automatic test_max_legal();
      int t;
      int d;
      clear_mon();
      send_frame(4'd2, 3'd3, 6, MW, t);
      idle(MW + 6);
      n_checks++;
      if (n_erro !== 0) $display("FAIL max_no_oversize: got %0d pulses expected 0", n_erro); else n_pass++;
      n_checks++;
      if (cap_data.size() !== MW + 1) $display("FAIL max_count: got %0d writes expected %0d", cap_data.size(), MW + 1); else n_pass++;
      d = data_diff();
      n_checks++;
      if (d !== -1) $display("FAIL max_data: word %0d got %h expected %h", d, cap_data[d], exp_q[d]); else n_pass++;
   endtask

   task automatic test_oversize();
      int t;
      int d;
      int bad_en;
      clear_mon();
      send_frame(4'd2, 3'd5, 7, MW + 1, t);
      idle(MW + 8);
      n_checks++;
      if (n_erro !== 1) $display("FAIL oversize_pulse: got %0d pulses expected 1", n_erro); else n_pass++;
`ifdef FRAME_OVERSIZE_DROP_EN
      n_checks++;
      if (cap_data.size() !== 0) $display("FAIL oversize_drop: got %0d writes expected 0", cap_data.size()); else n_pass++;
`else
      n_checks++;
      if (cap_data.size() !== MW + 1) $display("FAIL oversize_trunc_count: got %0d writes expected %0d", cap_data.size(), MW + 1); else n_pass++;
      d = data_diff();
      n_checks++;
      if (d !== -1) $display("FAIL oversize_trunc_data: word %0d got %h expected %h", d, cap_data[d], exp_q[d]); else n_pass++;
      bad_en = 0;
      for (int i = 0; i < cap_en.size(); i++) if (cap_en[i] !== 16'h0004) bad_en++;
      n_checks++;
      if (bad_en !== 0) $display("FAIL oversize_port: got %0d bad strobes expected 0", bad_en); else n_pass++;
`endif
      n_checks++;
      if (dbg_state !== ST_IDLE) $display("FAIL oversize_end_state: got %0d expected %0d", dbg_state, ST_IDLE); else n_pass++;
   endtask

   task automatic test_reset_mid();
      int t;
      int d;
      clear_mon();
      send_frame(4'd5, 3'd1, 8, 6, t);
      idle(3);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (q_wr_en !== '0 || q_wr_data !== '0)
         $display("FAIL rstmid_outputs: got en %h data %h expected 0", q_wr_en, q_wr_data);
      else n_pass++;
      n_checks++;
      if (wr_ready !== 1'b1) $display("FAIL rstmid_ready: got %b expected 1", wr_ready); else n_pass++;
      idle(2);
      rst_n = 1'b1;
      idle(12);
      n_checks++;
      if (cap_data.size() !== 3) $display("FAIL rstmid_no_more_writes: got %0d writes expected 3", cap_data.size()); else n_pass++;
      clear_mon();
      send_frame(4'd11, 3'd5, 9, 2, t);
      idle(6);
      d = data_diff();
      n_checks++;
      if (cap_data.size() !== 3 || d !== -1)
         $display("FAIL rstmid_recover: got %0d writes first bad %0d expected 3 writes none bad", cap_data.size(), d);
      else n_pass++;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_basic();
      test_single();
      test_stall();
      test_proto();
      test_max_legal();
      test_oversize();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
